rx_frame_fifo: RTL and testbench

- Parametrised store-and-forward receive FIFO. Sits between the MAC receive byte path and the frame consumer, e.g. the pattern checker or AXI-stream sink.
- Accepts beats of DATA_W bits with frame delimiters. A frame becomes visible to the reader only after its last beat arrives error-free.
- Frames with errors, or frames that overflow, are discarded by rewinding the write pointer. All DEPTH entries are usable.

---
 rtl/rx_frame_fifo.sv | 168 ++++++++++++++++
 tb/tb_rx_frame_fifo.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_frame_fifo.sv
// Store-and-forward receive FIFO: frames become readable only once committed error-free.
// Optional stats ports (drop_cnt, ovf_sticky) enabled by defining RX_FRAME_FIFO_STATS_EN.
module rx_frame_fifo #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 2048,
  parameter int FRM_CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_valid,
  input  logic [DATA_W-1:0]      wr_data,
  input  logic                   wr_last,
  input  logic                   wr_err,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [DATA_W-1:0]      rd_data,
  output logic                   rd_last,
  output logic [$clog2(DEPTH):0] level,
  output logic [FRM_CNT_W-1:0]   frames_avail,
  output logic                   drop_pulse
`ifdef RX_FRAME_FIFO_STATS_EN
  ,
  output logic [15:0]            drop_cnt,
  output logic                   ovf_sticky
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;
  localparam logic [1:0] S_DISC = 2'd2;

  logic [DATA_W:0]      mem_q [DEPTH];
  logic [1:0]           state_q, state_d;
  logic [PW-1:0]        wptr_q, wptr_d, cptr_q, cptr_d, cvis_q, rptr_q, rcons_q;
  logic                 we, commit, drop_d, disc_enter, full;
  logic                 rvld_q, rlast_q, drop_q, load, pop;
  logic [DATA_W-1:0]    rdata_q;
  logic [PW-1:0]        level_q;
  logic [FRM_CNT_W-1:0] fa_q, fa_d;
  logic [DATA_W:0]      rd_word;

  // Occupancy is measured against consumed beats, so the output register never frees a slot early.
  assign full = (wptr_q - rcons_q) == PW'(DEPTH);

  always_comb begin
    state_d    = state_q;
    wptr_d     = wptr_q;
    cptr_d     = cptr_q;
    we         = 1'b0;
    commit     = 1'b0;
    drop_d     = 1'b0;
    disc_enter = 1'b0;
    if (wr_valid) begin
      if (state_q == S_DISC) begin
        if (wr_last) begin
          wptr_d  = cptr_q;
          drop_d  = 1'b1;
          state_d = S_IDLE;
        end
      end else if (full) begin
        if (wr_last) begin
          wptr_d  = cptr_q;
          drop_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          state_d    = S_DISC;
          disc_enter = 1'b1;
        end
      end else if (wr_last) begin
        state_d = S_IDLE;
        if (wr_err) begin
          wptr_d = cptr_q;
          drop_d = 1'b1;
        end else begin
          we     = 1'b1;
          commit = 1'b1;
          wptr_d = wptr_q + 1'b1;
          cptr_d = wptr_q + 1'b1;
        end
      end else begin
        we      = 1'b1;
        wptr_d  = wptr_q + 1'b1;
        state_d = S_RECV;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem_q[wptr_q[AW-1:0]] <= {wr_last, wr_data};
  end

  // cvis lags cptr by one cycle so a fresh commit reaches the output two cycles later.
  assign rd_word = mem_q[rptr_q[AW-1:0]];
  assign pop     = rvld_q && rd_ready;
  assign load    = (rptr_q != cvis_q) && (!rvld_q || rd_ready);

  always_comb begin
    fa_d = fa_q;
    if (commit && !(pop && rlast_q)) begin
      if (fa_q != '1) fa_d = fa_q + 1'b1;
    end else if (!commit && pop && rlast_q) begin
      if (fa_q != '0) fa_d = fa_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      wptr_q  <= '0;
      cptr_q  <= '0;
      cvis_q  <= '0;
      rptr_q  <= '0;
      rcons_q <= '0;
      rvld_q  <= 1'b0;
      rdata_q <= '0;
      rlast_q <= 1'b0;
      level_q <= '0;
      fa_q    <= '0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      cptr_q  <= cptr_d;
      cvis_q  <= cptr_q;
      level_q <= cptr_q - rcons_q;
      fa_q    <= fa_d;
      drop_q  <= drop_d;
      if (pop) rcons_q <= rcons_q + 1'b1;
      if (load) begin
        rdata_q <= rd_word[DATA_W-1:0];
        rlast_q <= rd_word[DATA_W];
        rvld_q  <= 1'b1;
        rptr_q  <= rptr_q + 1'b1;
      end else if (pop) begin
        rvld_q  <= 1'b0;
      end
    end
  end

  assign rd_valid     = rvld_q;
  assign rd_data      = rdata_q;
  assign rd_last      = rlast_q;
  assign level        = level_q;
  assign frames_avail = fa_q;
  assign drop_pulse   = drop_q;

`ifdef RX_FRAME_FIFO_STATS_EN
  logic [15:0] drop_cnt_q;
  logic        ovf_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      drop_cnt_q <= '0;
      ovf_q      <= 1'b0;
    end else begin
      if (drop_d && drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 1'b1;
      if (disc_enter) ovf_q <= 1'b1;
    end
  end

  assign drop_cnt   = drop_cnt_q;
  assign ovf_sticky = ovf_q;
`endif

endmodule

// File: tb/tb_rx_frame_fifo.sv
// Bench for rx_frame_fifo (DEPTH=16): queue-level frame model checked every cycle,
// plus hand-computed expectations per scenario.
module tb_rx_frame_fifo;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       wr_valid = 1'b0, wr_last = 1'b0, wr_err = 1'b0, rd_ready = 1'b0;
  logic [7:0] wr_data = '0;
  logic       rd_valid, rd_last, drop_pulse;
  logic [7:0] rd_data;
  logic [4:0] level;
  logic [7:0] frames_avail;
`ifdef RX_FRAME_FIFO_STATS_EN
  logic [15:0] drop_cnt;
  logic        ovf_sticky;
`endif

  always #5 clk = ~clk;

  rx_frame_fifo #(.DATA_W(8), .DEPTH(16), .FRM_CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_data(wr_data), .wr_last(wr_last), .wr_err(wr_err),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .level(level), .frames_avail(frames_avail), .drop_pulse(drop_pulse)
`ifdef RX_FRAME_FIFO_STATS_EN
    , .drop_cnt(drop_cnt), .ovf_sticky(ovf_sticky)
`endif
  );

  int nvec = 0, nerr = 0;

  task automatic check(input string nm, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Frame-level model: stored beats, in-progress frame, output register.
  typedef struct { logic [8:0] b; int vis; } cbeat_t;
  cbeat_t     cq[$];
  logic [7:0] pend[$];
  logic       disc = 1'b0;
  logic       m_ov = 1'b0, m_ol = 1'b0, m_drop = 1'b0;
  logic [7:0] m_od = '0;
  int         m_lvl = 0, m_fa = 0, ecyc = 0;

  task automatic model_step(input logic rst, input logic v, input logic [7:0] d,
                            input logic l, input logic e, input logic r);
    logic pop, full, commit, dec;
    int   stored;
    if (!rst) begin
      cq.delete(); pend.delete();
      disc = 0; m_ov = 0; m_od = '0; m_ol = 0; m_lvl = 0; m_fa = 0; m_drop = 0;
    end else begin
      stored = cq.size() + int'(m_ov);
      m_lvl  = stored;
      pop    = m_ov && r;
      dec    = pop && m_ol;
      full   = (pend.size() + stored) == 16;
      commit = 0;
      m_drop = 0;
      if (v) begin
        if (disc) begin
          if (l) begin pend.delete(); disc = 0; m_drop = 1; end
        end else if (full) begin
          if (l) begin pend.delete(); m_drop = 1; end
          else disc = 1;
        end else if (l) begin
          if (e) begin pend.delete(); m_drop = 1; end
          else begin
            foreach (pend[i]) cq.push_back('{b: {1'b0, pend[i]}, vis: ecyc + 2});
            cq.push_back('{b: {1'b1, d}, vis: ecyc + 2});
            pend.delete();
            commit = 1;
          end
        end else pend.push_back(d);
      end
      if (cq.size() > 0 && cq[0].vis <= ecyc && (!m_ov || r)) begin
        m_od = cq[0].b[7:0]; m_ol = cq[0].b[8]; m_ov = 1;
        void'(cq.pop_front());
      end else if (pop) m_ov = 0;
      if (commit && !dec && m_fa < 255) m_fa++;
      else if (dec && !commit && m_fa > 0) m_fa--;
    end
    ecyc++;
  endtask

  logic [8:0] log_q[$];

  task automatic cyc(input logic v, input logic [7:0] d, input logic l,
                     input logic e, input logic r);
    wr_valid = v; wr_data = d; wr_last = l; wr_err = e; rd_ready = r;
    #1;
    if (rst_n && rd_valid && rd_ready) log_q.push_back({rd_last, rd_data});
    @(posedge clk);
    model_step(rst_n, v, d, l, e, r);
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic r);
    for (int i = 0; i < n; i++) cyc(1'b0, 8'h00, 1'b0, 1'b0, r);
  endtask

  task automatic expect_frame(input string nm, input logic [7:0] first, input int n);
    logic [8:0] got;
    for (int i = 0; i < n; i++) begin
      if (log_q.size() == 0) begin
        check({nm, " beat missing"}, 1, 0);
        return;
      end
      got = log_q.pop_front();
      check({nm, " beat"}, int'(got), int'({i == n - 1, 8'(first + i)}));
    end
  endtask

  logic chk_on = 1'b0;
  int   ndrop = 0, maxlvl = 0;

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      check("rd_valid", int'(rd_valid), int'(m_ov));
      if (m_ov) check("rd_beat", int'({rd_last, rd_data}), int'({m_ol, m_od}));
      check("level", int'(level), m_lvl);
      check("frames_avail", int'(frames_avail), m_fa);
      check("drop_pulse", int'(drop_pulse), int'(m_drop));
      if (drop_pulse) ndrop++;
      if (int'(level) > maxlvl) maxlvl = int'(level);
    end
  end

  initial begin
    int d0;
    logic tog;
    @(negedge clk);
    idle(2, 1'b0);
    chk_on = 1'b1;
    check("reset rd_valid", int'(rd_valid), 0);
    check("reset rd_data", int'(rd_data), 0);
    check("reset level", int'(level), 0);
`ifdef RX_FRAME_FIFO_STATS_EN
    check("reset drop_cnt", int'(drop_cnt), 0);
`endif
    rst_n = 1'b1;

    // single 5-beat frame, 2-cycle visibility latency
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h11 + i), i == 4, 1'b0, 1'b1);
    check("single rd_valid+0", int'(rd_valid), 0);
    idle(1, 1'b1);
    check("single rd_valid+1", int'(rd_valid), 0);
    check("single frames_avail", int'(frames_avail), 1);
    check("single level", int'(level), 5);
    idle(1, 1'b1);
    check("single rd_valid+2", int'(rd_valid), 1);
    check("single first data", int'(rd_data), 8'h11);
    idle(8, 1'b1);
    expect_frame("single", 8'h11, 5);
    check("single frames_avail end", int'(frames_avail), 0);
    check("single level end", int'(level), 0);

    // bad frame then good frame
    maxlvl = 0;
    for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'h21 + i), i == 3, i == 3, 1'b1);
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h31 + i), i == 2, 1'b0, 1'b1);
    idle(8, 1'b1);
    expect_frame("badgood", 8'h31, 3);
    check("badgood log empty", log_q.size(), 0);
    check("badgood drops", ndrop, 1);
    check("badgood max level", maxlvl, 3);

    // overflow of a 20-beat frame, then exactly DEPTH beats
    for (int i = 0; i < 20; i++) cyc(1'b1, 8'(8'h40 + i), i == 19, 1'b0, 1'b0);
    idle(3, 1'b0);
    check("ovf drops", ndrop, 2);
    check("ovf level", int'(level), 0);
    check("ovf rd_valid", int'(rd_valid), 0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h60 + i), i == 15, 1'b0, 1'b0);
    idle(3, 1'b0);
    check("full level", int'(level), 16);
    check("full rd_valid", int'(rd_valid), 1);
    check("full rd_data", int'(rd_data), 8'h60);
    cyc(1'b1, 8'h7F, 1'b1, 1'b0, 1'b0);
    idle(1, 1'b0);
    check("full extra dropped", ndrop, 3);
    check("full level kept", int'(level), 16);
    idle(20, 1'b1);
    expect_frame("full", 8'h60, 16);

    // wrap with toggling back-pressure
    tog = 1'b0;
    for (int f = 0; f < 3; f++)
      for (int i = 0; i < 7; i++) begin
        cyc(1'b1, 8'(8'h80 + 7 * f + i), i == 6, 1'b0, tog);
        tog = ~tog;
      end
    for (int i = 0; i < 40; i++) begin
      cyc(1'b0, 8'h00, 1'b0, 1'b0, tog);
      tog = ~tog;
    end
    for (int f = 0; f < 3; f++) begin
      d0 = 8'h80 + 7 * f;
      expect_frame("wrap", 8'(d0), 7);
    end
    check("wrap log empty", log_q.size(), 0);

    // commit coinciding with rd_last handshake
    cyc(1'b1, 8'hA1, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'hA2, 1'b1, 1'b0, 1'b0);
    idle(3, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hB1, 1'b1, 1'b0, 1'b1);
    check("simul frames_avail", int'(frames_avail), 1);
    check("simul gap", int'(rd_valid), 0);
    idle(2, 1'b0);
    check("simul rd_valid", int'(rd_valid), 1);
    check("simul rd_beat", int'({rd_last, rd_data}), int'(9'h1B1));
    idle(3, 1'b1);
    expect_frame("simulA", 8'hA1, 2);
    expect_frame("simulB", 8'hB1, 1);

    // reset in the middle of a frame
    d0 = ndrop;
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'hC1 + i), 1'b0, 1'b0, 1'b1);
    rst_n = 1'b0;
    idle(2, 1'b1);
    check("midrst rd_valid", int'(rd_valid), 0);
    check("midrst rd_data", int'(rd_data), 0);
    check("midrst level", int'(level), 0);
    check("midrst frames_avail", int'(frames_avail), 0);
`ifdef RX_FRAME_FIFO_STATS_EN
    check("midrst drop_cnt", int'(drop_cnt), 0);
`endif
    rst_n = 1'b1;
    cyc(1'b1, 8'hD1, 1'b0, 1'b0, 1'b1);
    cyc(1'b1, 8'hD2, 1'b1, 1'b0, 1'b1);
    idle(6, 1'b1);
    check("midrst no drop", ndrop, d0);
    expect_frame("postrst", 8'hD1, 2);
    check("postrst log empty", log_q.size(), 0);

    chk_on = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
